// File: rtl/tone_sample_gen_if.sv
// Handshake bundle between the tone generator and its note source / sample sink.
// The master side issues notes and consumes samples; the slave side is the generator.
interface tone_sample_gen_if #(
  parameter int WIDTH    = 16,
  parameter int PERIOD_W = 10,
  parameter int DUR_W    = 16
);
  logic                note_valid;
  logic                note_ready;
  logic [PERIOD_W-1:0] note_half_period;
  logic [DUR_W-1:0]    note_length;
  logic [WIDTH-2:0]    note_amp;
  logic [WIDTH-1:0]    sample_data;
  logic                sample_valid;
  logic                sample_ready;
  logic                busy;
  logic                overrun;

  modport master (
    output note_valid, note_half_period, note_length, note_amp, sample_ready,
    input  note_ready, sample_data, sample_valid, busy, overrun
  );

  modport slave (
    input  note_valid, note_half_period, note_length, note_amp, sample_ready,
    output note_ready, sample_data, sample_valid, busy, overrun
  );
endinterface

// File: rtl/tone_sample_gen.sv
// Square-wave tone generator: one signed PCM sample per sample_clk rising edge,
// silence between notes, sticky overrun when a sample is overwritten unconsumed.
module tone_sample_gen #(
  parameter int WIDTH    = 16,
  parameter int PERIOD_W = 10,
  parameter int DUR_W    = 16
) (
  input  logic              in_clk,
  input  logic              resetn,
  input  logic              sample_clk,
  tone_sample_gen_if.slave  bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              r_state;
  logic                r_prev;
  logic [PERIOD_W-1:0] r_halfPeriod;
  logic [PERIOD_W-1:0] r_phaseCnt;
  logic [DUR_W-1:0]    r_remaining;
  logic [WIDTH-2:0]    r_amp;
  logic                r_phase;
  logic [WIDTH-1:0]    r_sampleData;
  logic                r_sampleValid;
  logic                r_overrun;

  logic                w_tick;
  logic [WIDTH-1:0]    w_ampExt;
  logic [WIDTH-1:0]    w_sample;

  assign w_tick   = sample_clk & ~r_prev;
  assign w_ampExt = {1'b0, r_amp};
  // The sample comes from the pre-edge state, so a note accepted on a tick cycle still emits silence there.
  assign w_sample = (r_state == PLAY) ? (r_phase ? -w_ampExt : w_ampExt) : '0;

  assign bus.note_ready   = (r_state == IDLE);
  assign bus.busy         = (r_state == PLAY);
  assign bus.sample_data  = r_sampleData;
  assign bus.sample_valid = r_sampleValid;
  assign bus.overrun      = r_overrun;

  always_ff @(posedge in_clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_prev        <= 1'b0;
      r_halfPeriod  <= '0;
      r_phaseCnt    <= '0;
      r_remaining   <= '0;
      r_amp         <= '0;
      r_phase       <= 1'b0;
      r_sampleData  <= '0;
      r_sampleValid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_prev <= sample_clk;

      if (w_tick) begin
        r_sampleData  <= w_sample;
        r_sampleValid <= 1'b1;
        if (r_sampleValid & ~bus.sample_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_sampleValid & bus.sample_ready) begin
        r_sampleValid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (bus.note_valid) begin
            r_halfPeriod <= bus.note_half_period;
            r_amp        <= bus.note_amp;
            // Zero half-period or zero length is swallowed without playing anything.
            if ((bus.note_half_period != '0) && (bus.note_length != '0)) begin
              r_state     <= PLAY;
              r_phase     <= 1'b0;
              r_phaseCnt  <= '0;
              r_remaining <= bus.note_length;
            end
          end
        end
        PLAY: begin
          if (w_tick) begin
            if (r_phaseCnt == r_halfPeriod - PERIOD_W'(1)) begin
              r_phaseCnt <= '0;
              r_phase    <= ~r_phase;
            end else begin
              r_phaseCnt <= r_phaseCnt + PERIOD_W'(1);
            end
            r_remaining <= r_remaining - DUR_W'(1);
            if (r_remaining == DUR_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sample_gen.sv
// Bench for tone_sample_gen: hand-computed note table, corner sequences and
// randomized traffic checked against a queue-based model of the sample stream.
module tb_tone_sample_gen;
  localparam int WIDTH    = 16;
  localparam int PERIOD_W = 10;
  localparam int DUR_W    = 16;

  logic in_clk     = 1'b0;
  logic resetn     = 1'b0;
  logic sample_clk = 1'b0;

  tone_sample_gen_if #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) bus();

  tone_sample_gen #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) dut (
    .in_clk     (in_clk),
    .resetn     (resetn),
    .sample_clk (sample_clk),
    .bus        (bus)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0]        hp;
    logic [15:0]       len;
    logic [14:0]       amp;
    logic [7:0][15:0]  expSeq;
  } vec_t;

  vec_t vecs [7];

  // Model: a note becomes the list of samples it will produce; each tick pops one (or 0 if empty).
  int   mQ [$];
  logic mPrev;
  logic mValid;
  int   mData;
  logic mOverrun;

  always @(posedge in_clk or negedge resetn) begin
    if (!resetn) begin
      mQ.delete();
      mPrev    = 1'b0;
      mValid   = 1'b0;
      mData    = 0;
      mOverrun = 1'b0;
    end else begin
      logic tick;
      logic rdy;
      int   hp;
      int   len;
      int   amp;
      tick  = sample_clk && !mPrev;
      mPrev = sample_clk;
      rdy   = (mQ.size() == 0);
      if (tick) begin
        if (mValid && !bus.sample_ready) mOverrun = 1'b1;
        if (mQ.size() != 0) mData = mQ.pop_front();
        else mData = 0;
        mValid = 1'b1;
      end else if (mValid && bus.sample_ready) begin
        mValid = 1'b0;
      end
      hp  = int'(bus.note_half_period);
      len = int'(bus.note_length);
      amp = int'(bus.note_amp);
      if (rdy && bus.note_valid && hp != 0 && len != 0) begin
        for (int i = 0; i < len; i++) mQ.push_back((((i / hp) % 2) != 0) ? -amp : amp);
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, " data"},    int'($signed(bus.sample_data)), mData);
    cmp({tag, " valid"},   int'(bus.sample_valid), int'(mValid));
    cmp({tag, " busy"},    int'(bus.busy), (mQ.size() != 0) ? 1 : 0);
    cmp({tag, " ready"},   int'(bus.note_ready), (mQ.size() == 0) ? 1 : 0);
    cmp({tag, " overrun"}, int'(bus.overrun), int'(mOverrun));
  endtask

  task automatic applyStimulus(input logic sclk, input logic nv, input logic sr);
    @(negedge in_clk);
    checkOutput("model");
    sample_clk       = sclk;
    bus.note_valid   = nv;
    bus.sample_ready = sr;
  endtask

  task automatic setNote(input int hp, input int len, input int amp);
    bus.note_half_period = PERIOD_W'(hp);
    bus.note_length      = DUR_W'(len);
    bus.note_amp         = (WIDTH-1)'(amp);
  endtask

  task automatic doTick(input logic sr);
    applyStimulus(1'b1, 1'b0, sr);
    applyStimulus(1'b0, 1'b0, sr);
  endtask

  task automatic sendNote(input int hp, input int len, input int amp);
    setNote(hp, len, amp);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  function automatic vec_t mkVec(input int hp, input int len, input int amp,
                                 input int e0, input int e1, input int e2, input int e3,
                                 input int e4, input int e5, input int e6, input int e7);
    vec_t v;
    v.hp        = hp[9:0];
    v.len       = len[15:0];
    v.amp       = amp[14:0];
    v.expSeq[0] = e0[15:0];
    v.expSeq[1] = e1[15:0];
    v.expSeq[2] = e2[15:0];
    v.expSeq[3] = e3[15:0];
    v.expSeq[4] = e4[15:0];
    v.expSeq[5] = e5[15:0];
    v.expSeq[6] = e6[15:0];
    v.expSeq[7] = e7[15:0];
    return v;
  endfunction

  initial begin
    bus.note_valid   = 1'b0;
    bus.sample_ready = 1'b0;
    setNote(0, 0, 0);

    vecs[0] = mkVec(2, 6, 1000,  1000, 1000, -1000, -1000, 1000, 1000, 0, 0);
    vecs[1] = mkVec(3, 3, 7,     7, 7, 7, 0, 0, 0, 0, 0);
    vecs[2] = mkVec(1, 4, 300,   300, -300, 300, -300, 0, 0, 0, 0);
    vecs[3] = mkVec(0, 5, 500,   0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mkVec(2, 0, 500,   0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mkVec(1, 3, 32767, 32767, -32767, 32767, 0, 0, 0, 0, 0);
    vecs[6] = mkVec(5, 7, 1,     1, 1, 1, 1, 1, -1, -1, 0);

    // Reset held with sample_clk toggling
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b0, 1'b0);
    cmp("reset data",    int'(bus.sample_data), 0);
    cmp("reset valid",   int'(bus.sample_valid), 0);
    cmp("reset overrun", int'(bus.overrun), 0);
    cmp("reset busy",    int'(bus.busy), 0);
    cmp("reset ready",   int'(bus.note_ready), 1);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    doTick(1'b1);
    doTick(1'b1);
    cmp("post-reset silence", int'($signed(bus.sample_data)), 0);

    // Table-driven notes
    for (int v = 0; v < 7; v++) begin
      sendNote(int'(vecs[v].hp), int'(vecs[v].len), int'(vecs[v].amp));
      for (int k = 0; k < 8; k++) begin
        doTick(1'b1);
        cmp($sformatf("vec%0d s%0d", v, k), int'($signed(bus.sample_data)),
            int'($signed(vecs[v].expSeq[k])));
        cmp($sformatf("vec%0d busy%0d", v, k), int'(bus.busy), (k < int'(vecs[v].len) - 1 && vecs[v].hp != 0) ? 1 : 0);
      end
    end

    // Backpressure: two ticks unconsumed
    sendNote(1, 4, 300);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doTick(1'b0);
    doTick(1'b0);
    cmp("bp overrun", int'(bus.overrun), 1);
    cmp("bp data",    int'($signed(bus.sample_data)), -300);
    doTick(1'b1);
    doTick(1'b1);
    doTick(1'b1);
    cmp("bp overrun sticky", int'(bus.overrun), 1);
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    // Coincident tick and handshake
    doTick(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cmp("coinc valid",   int'(bus.sample_valid), 1);
    cmp("coinc overrun", int'(bus.overrun), 0);

    // Note accepted on a tick cycle starts at the next tick
    setNote(3, 3, 7);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("tick-accept data", int'($signed(bus.sample_data)), 0);
    cmp("tick-accept busy", int'(bus.busy), 1);
    doTick(1'b1);
    cmp("tick-accept s0", int'($signed(bus.sample_data)), 7);

    // Mid-note reset
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    sendNote(2, 100, 50);
    for (int k = 0; k < 10; k++) doTick(1'b1);
    resetn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    cmp("midreset data",  int'(bus.sample_data), 0);
    cmp("midreset valid", int'(bus.sample_valid), 0);
    cmp("midreset busy",  int'(bus.busy), 0);
    cmp("midreset ready", int'(bus.note_ready), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendNote(3, 3, 7);
    for (int k = 0; k < 3; k++) begin
      doTick(1'b1);
      cmp($sformatf("after reset s%0d", k), int'($signed(bus.sample_data)), 7);
    end
    doTick(1'b1);
    cmp("after reset busy", int'(bus.busy), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      setNote($urandom_range(0, 4), $urandom_range(0, 10), $urandom_range(0, 32767));
      applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tone_sample_gen.md
# tone_sample_gen

Square-wave tone generator for the audio path. It consumes the 48 kHz-class divided clock from `rate_divider_16` as a sample tick. Per note request it emits a stream of signed PCM samples (period, length and amplitude set by the request) toward the audio codec interface over a valid/ready handshake. Between notes it emits silence, so the codec receives one sample per tick at all times.

## Interface
- `WIDTH`, 16, sample width in bits (signed two's complement)
- `PERIOD_W`, 10, width of half-period field (in samples)
- `DUR_W`, 16, width of note length field (in samples)

- `in_clk`  in  1  system clock; sole clock of the block
- `resetn`  in  1  asynchronous, active-low reset
- `sample_clk`  in  1  divided clock from `rate_divider_16`, same `in_clk` domain; each rising edge = one sample tick
- `note_valid`  in  1  note request present
- `note_ready`  out  1  block can accept a note
- `note_half_period`  in  PERIOD_W  samples per half-cycle of the square wave
- `note_length`  in  DUR_W  note duration in samples
- `note_amp`  in  WIDTH-1  unsigned amplitude magnitude
- `sample_data`  out  WIDTH  registered signed sample
- `sample_valid`  out  1  `sample_data` holds an unconsumed sample
- `sample_ready`  in  1  downstream accepts sample
- `busy`  out  1  note playing
- `overrun`  out  1  sticky: an unconsumed sample was overwritten

## Operation
- Tick detect: register `prev` <= `sample_clk`; `tick` = `sample_clk & ~prev`. `prev` resets to 0.
- States: IDLE, PLAY. `busy` = (state == PLAY); `note_ready` = (state == IDLE), combinational from state.
- IDLE, `note_valid & note_ready`: latch half_period, length, amp. If half_period == 0 or length == 0, the note is consumed and the state stays IDLE. Otherwise go to PLAY with phase = 0 (positive), phase_cnt = 0, remaining = length.
- Every tick produces exactly one sample, chosen from the state *before* any same-cycle note acceptance:
  - IDLE: sample = 0.
  - PLAY: sample = phase ? −amp : +amp. Amp is zero-extended to WIDTH; negation is two's complement, so the range is ±(2^(WIDTH−1)−1) and never overflows.
- PLAY bookkeeping on each tick:
  - If phase_cnt == half_period−1: phase_cnt <= 0 and phase toggles. Otherwise phase_cnt increments.
  - remaining decrements. If remaining == 1 on this tick, the state becomes IDLE.
- Output register:
  - On tick: `sample_data` <= sample, `sample_valid` <= 1.
  - On tick while `sample_valid & ~sample_ready`: `overrun` <= 1 and the new sample overwrites the old.
  - No tick, and `sample_valid & sample_ready`: `sample_valid` <= 0; `sample_data` holds.
  - Tick and handshake in the same cycle: new sample loads, `sample_valid` stays 1, no overrun.
- `overrun` clears only on reset.
- Reset (any time, including mid-note): state IDLE. `sample_data`=0, `sample_valid`=0, `overrun`=0, `busy`=0, `note_ready`=1, and all counters and latches are 0. The note in progress is discarded.

## Timing
- `sample_data`/`sample_valid` update on the `in_clk` edge ending the tick cycle, so they are visible one cycle after `sample_clk` is seen high.
- A note accepted in cycle N takes effect from the first tick strictly after N. A tick in cycle N itself emits silence.
- `busy` falls on the edge that outputs the last note sample. `note_ready` rises with it, and a new note may be accepted the cycle after the last sample is registered.
- With `rate_divider_16` upstream, ticks are 32 `in_clk` cycles apart. Downstream must consume each sample within 32 cycles to avoid overrun.
- No combinational path from `note_valid` or `sample_ready` to any output.

## Test plan
- Reset: hold `resetn`=0 with `sample_clk` toggling. Required: `sample_valid`=0, `sample_data`=0, `overrun`=0, `busy`=0, `note_ready`=1. After release, ticks yield samples of 0.
- Basic note: half_period=2, length=6, amp=1000, `sample_ready`=1. Required sample sequence: +1000, +1000, −1000, −1000, +1000, +1000, then 0s. `busy` is 1 for exactly those 6 ticks.
- Degenerate notes: length=0, then half_period=0 (amp=500). Each is accepted in one cycle, `busy` stays 0, and output stays 0.
- Backpressure: playing amp=300, half_period=1, `sample_ready`=0 across two ticks. Required: `overrun`=1, `sample_data`=−300 (the second sample). `overrun` stays 1 after `sample_ready` returns.
- Coincident tick and handshake: drive `sample_ready`=1 only in the tick cycle. Required: new sample loaded, `sample_valid` stays 1, `overrun` stays 0. Also check that a note accepted in a tick cycle starts at the following tick.
- Mid-note reset: length=100, assert `resetn`=0 after 10 samples. Required: all outputs at reset values. A new note (half_period=3, length=3, amp=7) then yields +7, +7, +7.
